// File: rtl/ps2_keyboard_mmio_if.sv
// CPU load bus between the processor FSM and the PS/2 keyboard receiver.
// The CPU side is the master; the keyboard register window is the slave.
interface ps2_keyboard_mmio_if #(
    parameter int unsigned WORD_SIZE = 32
);
    logic                 rd_en;
    logic [WORD_SIZE-1:0] address;
    logic [WORD_SIZE-1:0] rd_data;
    logic                 rd_valid;

    modport master (output rd_en, address, input rd_data, rd_valid);
    modport slave  (input rd_en, address, output rd_data, rd_valid);
endinterface

// File: rtl/ps2_keyboard_mmio.sv
// PS/2 keyboard receiver: it conditions the line, deserializes frames and
// buffers good bytes in a FIFO. The CPU reads them through a DATA/STATUS window.
module ps2_keyboard_mmio #(
    parameter int unsigned          WORD_SIZE      = 32,
    parameter logic [WORD_SIZE-1:0] BASE_ADDR      = 32'h00030000,
    parameter int unsigned          FIFO_DEPTH     = 8,
    parameter int unsigned          FILTER_LEN     = 4,
    parameter int unsigned          TIMEOUT_CYCLES = 50000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ps2_clk,
    input  logic                 ps2_dat,
    ps2_keyboard_mmio_if.slave   bus,
    output logic                 key_avail,
    output logic                 rx_busy
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned FLT_W = $clog2(FILTER_LEN) + 1;
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES) + 1;

    localparam logic [CNT_W-1:0]     DEPTH_C   = CNT_W'(FIFO_DEPTH);
    localparam logic [FLT_W-1:0]     FLT_LAST  = FLT_W'(FILTER_LEN - 1);
    localparam logic [TMO_W-1:0]     TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WORD_SIZE-1:0] STAT_ADDR = BASE_ADDR + WORD_SIZE'(4);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    logic             r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic             r_clk_f;
    logic [FLT_W-1:0] r_flt_cnt;
    logic             w_fe;

    state_t           r_state;
    logic [2:0]       r_bit_cnt;
    logic [7:0]       r_shift;
    logic             r_par;
    logic [TMO_W-1:0] r_tmo;
    logic             r_push;
    logic [7:0]       r_push_byte;
    logic             r_ferr_set;

    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_ovf, r_ferr;
    logic             r_rd_valid;
    logic [WORD_SIZE-1:0] r_rd_data;

    logic w_full, w_empty, w_hit_data, w_hit_stat, w_pop, w_push, w_ovf_set;
    logic [WORD_SIZE-1:0] w_rd_word;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
        end else begin
            r_clk_s1 <= ps2_clk;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= ps2_dat;
            r_dat_s2 <= r_dat_s1;
        end
    end

    // Filtered clock flips on the FILTER_LEN-th consecutive differing sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clk_f   <= 1'b1;
            r_flt_cnt <= '0;
        end else if (r_clk_s2 != r_clk_f) begin
            if (r_flt_cnt == FLT_LAST) begin
                r_clk_f   <= r_clk_s2;
                r_flt_cnt <= '0;
            end else begin
                r_flt_cnt <= r_flt_cnt + 1'b1;
            end
        end else begin
            r_flt_cnt <= '0;
        end
    end

    assign w_fe = r_clk_f & ~r_clk_s2 & (r_flt_cnt == FLT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_par       <= 1'b0;
            r_tmo       <= '0;
            r_push      <= 1'b0;
            r_push_byte <= '0;
            r_ferr_set  <= 1'b0;
        end else begin
            r_push     <= 1'b0;
            r_ferr_set <= 1'b0;
            if (w_fe || r_state == S_IDLE) r_tmo <= '0;
            else                           r_tmo <= r_tmo + 1'b1;

            if (r_state != S_IDLE && !w_fe && r_tmo == TMO_LAST) begin
                r_state    <= S_IDLE;
                r_ferr_set <= 1'b1;
                r_tmo      <= '0;
            end else if (w_fe) begin
                case (r_state)
                    S_IDLE: begin
                        if (!r_dat_s2) begin
                            r_state   <= S_DATA;
                            r_bit_cnt <= '0;
                        end
                    end
                    S_DATA: begin
                        r_shift   <= {r_dat_s2, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == 3'd7) r_state <= S_PARITY;
                    end
                    S_PARITY: begin
                        r_par   <= r_dat_s2;
                        r_state <= S_STOP;
                    end
                    S_STOP: begin
                        r_state <= S_IDLE;
                        if (r_dat_s2 && (^{r_shift, r_par})) begin
                            r_push      <= 1'b1;
                            r_push_byte <= r_shift;
                        end else begin
                            r_ferr_set  <= 1'b1;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign w_full     = (r_count == DEPTH_C);
    assign w_empty    = (r_count == '0);
    assign w_hit_data = bus.rd_en && (bus.address == BASE_ADDR);
    assign w_hit_stat = bus.rd_en && (bus.address == STAT_ADDR);
    assign w_pop      = w_hit_data && !w_empty;
    // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
    assign w_push     = r_push && (!w_full || w_pop);
    assign w_ovf_set  = r_push && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= r_push_byte;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_ferr   <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            r_ovf  <= w_ovf_set  | (r_ovf  & ~w_hit_stat);
            r_ferr <= r_ferr_set | (r_ferr & ~w_hit_stat);
        end
    end

    always_comb begin
        w_rd_word = '0;
        if (w_hit_data) begin
            if (!w_empty) begin
                w_rd_word[7:0]         = r_mem[r_rd_ptr];
                w_rd_word[WORD_SIZE-1] = 1'b1;
            end
        end else if (w_hit_stat) begin
            w_rd_word[17]   = r_ovf;
            w_rd_word[16]   = r_ferr;
            w_rd_word[15:0] = 16'(r_count);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_valid <= w_hit_data | w_hit_stat;
            if (w_hit_data | w_hit_stat) r_rd_data <= w_rd_word;
        end
    end

    assign bus.rd_data  = r_rd_data;
    assign bus.rd_valid = r_rd_valid;
    assign key_avail    = !w_empty;
    assign rx_busy      = (r_state != S_IDLE);
endmodule

// File: tb/tb_ps2_keyboard_mmio.sv
// Bench for ps2_keyboard_mmio: a byte queue plus two flags model the FIFO and
// the register map; directed scenarios come first, then a randomized mix.
module tb_ps2_keyboard_mmio;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned FLT   = 4;
    localparam int unsigned TMO   = 600;
    localparam int unsigned HALF  = 10;
    localparam logic [31:0] BASE  = 32'h00030000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ps2_clk = 1'b1;
    logic ps2_dat = 1'b1;
    logic key_avail, rx_busy;

    ps2_keyboard_mmio_if #(.WORD_SIZE(32)) bus ();

    ps2_keyboard_mmio #(
        .WORD_SIZE(32), .BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH),
        .FILTER_LEN(FLT), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
        .bus(bus), .key_avail(key_avail), .rx_busy(rx_busy)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    logic [7:0]  mq[$];
    logic        m_ov = 1'b0;
    logic        m_fe = 1'b0;
    bit          settled = 1'b0;
    logic        exp_v = 1'b0;
    logic [31:0] exp_d = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, want);
        end
    endtask

    task automatic idle();
        bus.rd_en   = 1'b0;
        bus.address = '0;
        exp_v       = 1'b0;
        exp_d       = '0;
    endtask

    // Drive one read strobe and derive its response from the model.
    task automatic issue(input logic [31:0] a);
        bus.rd_en   = 1'b1;
        bus.address = a;
        if (a == BASE) begin
            exp_v = 1'b1;
            if (mq.size() > 0) exp_d = {24'h800000, mq.pop_front()};
            else               exp_d = '0;
        end else if (a == BASE + 32'd4) begin
            exp_v = 1'b1;
            exp_d = {14'b0, m_ov, m_fe, 16'(mq.size())};
            m_ov  = 1'b0;
            m_fe  = 1'b0;
        end else begin
            exp_v = 1'b0;
            exp_d = '0;
        end
    endtask

    task automatic do_read(input logic [31:0] a, output logic v, output logic [31:0] d);
        @(negedge clk);
        issue(a);
        @(posedge clk);
        #1;
        v = bus.rd_valid;
        d = bus.rd_data;
        @(negedge clk);
        idle();
    endtask

    task automatic rd_lit(input logic [31:0] a, input logic [31:0] want, input string nm);
        logic v;
        logic [31:0] d;
        do_read(a, v, d);
        chk({nm, " valid"}, 32'(v), 32'd1);
        chk(nm, d, want);
    endtask

    function automatic logic [10:0] frame_bits(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        logic p;
        p = ~(^b) ^ bad_par;
        return {~bad_stop, p, b, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] f, input int n);
        settled = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ps2_dat = f[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
        end
    endtask

    // mode 0: plain, 1: DATA read on the push cycle, 2: measure push latency
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int mode);
        logic [10:0] f;
        int lat;
        f = frame_bits(b, bad_par, bad_stop);
        send_bits(f, 10);
        @(negedge clk);
        ps2_dat = f[10];
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        if (mode == 1) begin
            repeat (FLT + 2) @(posedge clk);
            @(negedge clk);
            issue(BASE);
            @(negedge clk);
            idle();
        end else if (mode == 2) begin
            lat = 0;
            for (int k = 1; k <= 40 && lat == 0; k++) begin
                @(posedge clk);
                #1;
                if (key_avail) lat = k;
            end
            chk("push_latency", 32'(lat), 32'(FLT + 3));
            @(negedge clk);
        end
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (HALF) @(negedge clk);
        if (!bad_par && !bad_stop) begin
            if (mq.size() >= DEPTH) m_ov = 1'b1;
            else                    mq.push_back(b);
        end else begin
            m_fe = 1'b1;
        end
        settled = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b1;
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        idle();
        repeat (3) @(negedge clk);
        chk("rst rd_data",   bus.rd_data,         32'd0);
        chk("rst rd_valid",  32'(bus.rd_valid),   32'd0);
        chk("rst key_avail", 32'(key_avail),      32'd0);
        chk("rst rx_busy",   32'(rx_busy),        32'd0);
        mq.delete();
        m_ov    = 1'b0;
        m_fe    = 1'b0;
        settled = 1'b1;
        rst     = 1'b0;
    endtask

    task automatic drain();
        logic v;
        logic [31:0] d;
        for (int i = 0; i < int'(DEPTH) + 1 && mq.size() > 0; i++) do_read(BASE, v, d);
        do_read(BASE + 32'd4, v, d);
    endtask

    initial begin : compare
        logic ev;
        logic [31:0] ed;
        forever begin
            @(posedge clk);
            ev = exp_v;
            ed = exp_d;
            #1;
            if (!rst) begin
                chk("rd_valid", 32'(bus.rd_valid), 32'(ev));
                if (ev) chk("rd_data", bus.rd_data, ed);
                if (settled) begin
                    chk("key_avail", 32'(key_avail), 32'(mq.size() != 0));
                    chk("rx_busy", 32'(rx_busy), 32'd0);
                end
            end
        end
    end

    initial begin : watchdog
        #1500000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1);
    end

    initial begin : stim
        logic v;
        logic [31:0] d;
        int r;
        logic [31:0] a1, a2;
        idle();
        do_reset();

        send_frame(8'h1C, 1'b0, 1'b0, 2);
        chk("1c key_avail", 32'(key_avail), 32'd1);
        rd_lit(BASE, 32'h8000001C, "1c data");
        chk("1c key_avail after", 32'(key_avail), 32'd0);

        send_frame(8'h1C, 1'b1, 1'b0, 0);
        rd_lit(BASE + 32'd4, 32'h00010000, "parity status");
        rd_lit(BASE + 32'd4, 32'h00000000, "parity status2");

        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b0, 0);
        rd_lit(BASE + 32'd4, 32'h00020008, "ovf status");
        for (int i = 1; i <= 8; i++) rd_lit(BASE, 32'h80000000 | 32'(i), "ovf data");
        rd_lit(BASE, 32'h00000000, "ovf empty");

        for (int i = 0; i < 8; i++) send_frame(8'h30 + 8'(i), 1'b0, 1'b0, 0);
        send_frame(8'h55, 1'b0, 1'b0, 1);
        rd_lit(BASE + 32'd4, 32'h00000008, "simul status");
        rd_lit(BASE, 32'h80000031, "simul head");
        drain();

        send_bits(frame_bits(8'hA5, 1'b0, 1'b0), 5);
        repeat (100) @(negedge clk);
        chk("busy mid frame", 32'(rx_busy), 32'd1);
        repeat (TMO) @(negedge clk);
        m_fe    = 1'b1;
        settled = 1'b1;
        chk("timeout busy", 32'(rx_busy), 32'd0);
        rd_lit(BASE + 32'd4, 32'h00010000, "timeout status");

        for (int g = 2; g < int'(FLT); g++) begin
            @(negedge clk);
            ps2_dat = 1'b0;
            ps2_clk = 1'b0;
            repeat (g) @(negedge clk);
            ps2_clk = 1'b1;
            repeat (20) @(negedge clk);
            chk("glitch busy", 32'(rx_busy), 32'd0);
        end
        ps2_dat = 1'b1;
        rd_lit(BASE + 32'd4, 32'h00000000, "glitch status");

        do_read(BASE + 32'd8, v, d);
        chk("unmapped valid", 32'(v), 32'd0);

        send_frame(8'h77, 1'b0, 1'b0, 0);
        send_bits(frame_bits(8'h1C, 1'b0, 1'b0), 5);
        do_reset();
        send_frame(8'h1C, 1'b0, 1'b0, 0);
        rd_lit(BASE, 32'h8000001C, "post reset data");

        for (int it = 0; it < 40; it++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2, 3: send_frame(8'($urandom_range(0, 255)), 1'b0, 1'b0, 0);
                4: send_frame(8'($urandom_range(0, 255)), 1'b1, 1'b0, 0);
                5: send_frame(8'($urandom_range(0, 255)), 1'b0, 1'b1, 0);
                6: do_read(BASE, v, d);
                7: do_read(BASE + 32'd4, v, d);
                8: begin
                    case ($urandom_range(0, 3))
                        0:       a1 = BASE + 32'd8;
                        1:       a1 = BASE + 32'd1;
                        2:       a1 = BASE - 32'd4;
                        default: a1 = BASE ^ 32'h00000100;
                    endcase
                    do_read(a1, v, d);
                end
                default: begin
                    a1 = ($urandom_range(0, 1) == 0) ? BASE : BASE + 32'd4;
                    a2 = ($urandom_range(0, 1) == 0) ? BASE : BASE + 32'd4;
                    @(negedge clk);
                    issue(a1);
                    @(negedge clk);
                    issue(a2);
                    @(negedge clk);
                    idle();
                end
            endcase
            repeat ($urandom_range(0, 5)) @(negedge clk);
        end
        drain();
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
